ahb_lite_interconnect: RTL

AHB_LITE_INTERCONNECT -- requirements
Module: ahb_lite_interconnect

---
 rtl/ahb_pkg.sv | 19 +
 rtl/ahb_default_slave.sv | 58 +++++
 rtl/ahb_lite_interconnect.sv | 101 ++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// AHB-Lite shared encodings: transfer types, responses
// and the default-slave state enum.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } ds_state_e;

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: answers unmapped NONSEQ/SEQ with a
// two-cycle ERROR and counts those errors.
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        hready_i,
    input  logic        dflt_sel_i,
    input  logic [1:0]  htrans_i,
    output logic        ready_o,
    output logic        resp_o,
    output logic [15:0] err_count_o
);

    ds_state_e   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        qual;

    assign qual = hready_i && dflt_sel_i &&
                  (htrans_i == HTRANS_NONSEQ ||
                   htrans_i == HTRANS_SEQ);

    // Outputs depend on state only, so HREADY feedback
    // from the bus mux never forms a combinational loop.
    assign ready_o     = (state_q != DS_ERR1);
    assign resp_o      = (state_q == DS_IDLE) ? HRESP_OKAY
                                              : HRESP_ERROR;
    assign err_count_o = cnt_q;

    // Next-state and saturating error count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            DS_IDLE: state_d = qual ? DS_ERR1 : DS_IDLE;
            DS_ERR1: state_d = DS_ERR2;
            DS_ERR2: state_d = qual ? DS_ERR1 : DS_IDLE;
            default: state_d = DS_IDLE;
        endcase
        if (state_d == DS_ERR1 && state_q != DS_ERR1 &&
            cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // State and counter registers.
    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            state_q <= DS_IDLE;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/ahb_lite_interconnect.sv
// AHB-Lite decoder/mux: combinational address decode,
// data-phase select register and response mux.
module ahb_lite_interconnect
    import ahb_pkg::*;
#(
    parameter int NUM_SLAVES = 2,
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE =
        {32'h0000_1000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK =
        {32'hFFFF_F000, 32'hFFFF_F000}
) (
    input  logic                         HCLK,
    input  logic                         HRESET,
    input  logic [ADDR_W-1:0]            HADDR,
    input  logic [1:0]                   HTRANS,
    input  logic [NUM_SLAVES-1:0]        HREADYOUT_S,
    input  logic [NUM_SLAVES-1:0]        HRESP_S,
    input  logic [NUM_SLAVES*DATA_W-1:0] HRDATA_S,
    output logic [NUM_SLAVES-1:0]        HSEL,
    output logic                         HREADY,
    output logic                         HRESP,
    output logic [DATA_W-1:0]            HRDATA,
    output logic [15:0]                  err_count
);

    logic [NUM_SLAVES-1:0] asel;
    logic [NUM_SLAVES-1:0] dsel_q, dsel_d;
    logic                  dflt_a;
    logic                  dflt_q;
    logic                  s_ready;
    logic                  s_resp;
    logic [DATA_W-1:0]     s_rdata;
    logic                  ds_ready;
    logic                  ds_resp;

    // Address decode; scanning downward lets the lowest
    // matching index overwrite any higher match.
    always_comb begin
        asel = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((HADDR & SLAVE_MASK[i*ADDR_W +: ADDR_W]) ==
                SLAVE_BASE[i*ADDR_W +: ADDR_W]) begin
                asel    = '0;
                asel[i] = 1'b1;
            end
        end
    end

    assign HSEL   = asel;
    assign dflt_a = ~|asel;
    assign dflt_q = ~|dsel_q;

    // Data-phase select follows decode only on HREADY.
    always_comb begin
        dsel_d = dsel_q;
        if (HREADY) begin
            dsel_d = asel;
        end
    end

    // Data-phase select register; all-zero is the default slave.
    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            dsel_q <= '0;
        end else begin
            dsel_q <= dsel_d;
        end
    end

    // One-hot AND-OR mux of the selected slave's response.
    always_comb begin
        s_ready = 1'b0;
        s_resp  = 1'b0;
        s_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            s_ready = s_ready | (dsel_q[i] & HREADYOUT_S[i]);
            s_resp  = s_resp  | (dsel_q[i] & HRESP_S[i]);
            s_rdata = s_rdata |
                      ({DATA_W{dsel_q[i]}} &
                       HRDATA_S[i*DATA_W +: DATA_W]);
        end
    end

    assign HREADY = dflt_q ? ds_ready : s_ready;
    assign HRESP  = dflt_q ? ds_resp  : s_resp;
    assign HRDATA = s_rdata;

    ahb_default_slave u_dflt (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .hready_i    (HREADY),
        .dflt_sel_i  (dflt_a),
        .htrans_i    (HTRANS),
        .ready_o     (ds_ready),
        .resp_o      (ds_resp),
        .err_count_o (err_count)
    );

endmodule
